// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the MIPS stall/forward controller.
//   shadow_entry_t : one in-flight destination tracked by the shadow pipeline.
//   e_src_t        : extra source/multiply-divide info held only by the E stage.
//   TNEW_* / TUSE_*: typical Tnew/Tuse encodings used by the decoder.
//   MUL_LAT_DEF / DIV_LAT_DEF : default HI/LO busy latencies.
// Field widths are sized for the largest supported configuration
// (REG_AW <= REG_AW_MAX, TW <= TW_MAX). Narrower inputs are zero-extended
// into the entries, so comparisons keep their unsigned meaning.
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_AW_MAX = 8;
  localparam int TW_MAX     = 4;

  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;
  localparam int TNEW_LINK = 0;

  localparam int TUSE_BRANCH   = 0;
  localparam int TUSE_ALU      = 1;
  localparam int TUSE_STORE_RT = 2;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] wa;
    logic                  we;
    logic [TW_MAX-1:0]     tnew;
  } shadow_entry_t;

  typedef struct packed {
    logic [REG_AW_MAX-1:0] rs;
    logic [REG_AW_MAX-1:0] rt;
    logic                  rs_use;
    logic                  rt_use;
    logic                  md_start;
    logic                  md_div;
  } e_src_t;

  // Tnew counts down as the producer moves along; it never wraps below zero.
  function automatic logic [TW_MAX-1:0] tnew_sat_dec(input logic [TW_MAX-1:0] t);
    return (t == '0) ? t : (t - TW_MAX'(1));
  endfunction

  // A stage supplies a source only if it really writes that non-zero register
  // and the consumer actually reads it.
  function automatic logic src_match(input shadow_entry_t         e,
                                     input logic [REG_AW_MAX-1:0] src,
                                     input logic                  src_use);
    return e.valid & e.we & (e.wa == src) & (src != '0) & src_use;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// -----------------------------------------------------------------------------
// md_busy_cnt
// HI/LO multiply/divide busy countdown.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   load_i     : a mult/div start is sitting in E this cycle
//   div_i      : that start is a divide (selects DIV_LAT instead of MUL_LAT)
//   busy_o     : count != 0
// The count loads at the end of the cycle the start occupies E, so busy is
// visible for exactly MUL_LAT/DIV_LAT cycles after that. A reload while busy
// simply restarts the count.
// -----------------------------------------------------------------------------
module md_busy_cnt #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/forward controller for an in-order MIPS pipeline (F/D/E/M/W and
// deeper). In-flight destinations are tracked in a private shadow pipeline
// (stage 1 = E ... stage STAGES), so Tnew never has to come back from the
// datapath.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   d_rs/d_rt           : D-stage source addresses
//   d_tuse_rs/d_tuse_rt : cycles until each source is consumed (0 = in D)
//   d_rs_use/d_rt_use   : D instruction really reads that source
//   d_wa/d_we/d_tnew    : D destination, write enable, Tnew on entering E
//   d_hilo              : D instruction touches HI/LO
//   d_md_start/d_md_div : D instruction is mult/div, and whether it divides
//   flush               : replace the D->E transfer with a bubble
//   stall               : hold PC and F/D, bubble into E
//   fwd_d_rs/fwd_d_rt   : D operand source, 0 = RF, k = shadow stage k
//   fwd_e_rs/fwd_e_rt   : E operand source, 0 = pipe register, k >= 2 = stage k
//   md_busy             : HI/LO unit busy
//   perf_stall_raw/perf_stall_hilo : only with HAZARD_PERF_EN, 32-bit
//                         wrapping counts of RAW / HI/LO stall cycles
// Stage handshake: there is no valid/ready pair; D is always presented and
// "stall | flush" is the single condition that turns the D->E move into a
// bubble, while F/D hold is governed by stall alone.
// Build option: define HAZARD_PERF_EN to add the stall performance counters.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int STAGES  = 3,
  parameter int TW      = 2,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int FW      = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic              d_rs_use,
  input  logic              d_rt_use,
  input  logic [REG_AW-1:0] d_wa,
  input  logic              d_we,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_hilo,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              flush,
  output logic              stall,
  output logic [FW-1:0]     fwd_d_rs,
  output logic [FW-1:0]     fwd_d_rt,
  output logic [FW-1:0]     fwd_e_rs,
  output logic [FW-1:0]     fwd_e_rt,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_stall_raw,
  output logic [31:0]       perf_stall_hilo,
`endif
  output logic              md_busy
);

  shadow_entry_t st_q [1:STAGES];
  shadow_entry_t st_d [1:STAGES];
  e_src_t        esrc_q, esrc_d;

  logic                  raw_rs, raw_rt, hilo_stall, e_md_start, md_busy_w;
  logic                  bubble;
  logic [REG_AW_MAX-1:0] rs_x, rt_x;
  logic [TW_MAX-1:0]     tuse_rs_x, tuse_rt_x;

  assign rs_x      = REG_AW_MAX'(d_rs);
  assign rt_x      = REG_AW_MAX'(d_rt);
  assign tuse_rs_x = TW_MAX'(d_tuse_rs);
  assign tuse_rt_x = TW_MAX'(d_tuse_rt);

  // ---------------------------------------------------------------------------
  // Hazard detection and D-stage forwarding
  // ---------------------------------------------------------------------------
  always_comb begin
    raw_rs   = 1'b0;
    raw_rt   = 1'b0;
    fwd_d_rs = '0;
    fwd_d_rt = '0;
    for (int k = 1; k <= STAGES; k++) begin
      if (src_match(st_q[k], rs_x, d_rs_use) && (st_q[k].tnew > tuse_rs_x)) raw_rs = 1'b1;
      if (src_match(st_q[k], rt_x, d_rt_use) && (st_q[k].tnew > tuse_rt_x)) raw_rt = 1'b1;
    end
    // Walk from the oldest stage towards E so the nearest match is written last.
    // A nearest match that is not ready yet forces 0; stall covers that case.
    for (int k = STAGES; k >= 1; k--) begin
      if (src_match(st_q[k], rs_x, d_rs_use)) fwd_d_rs = (st_q[k].tnew == '0) ? FW'(k) : '0;
      if (src_match(st_q[k], rt_x, d_rt_use)) fwd_d_rt = (st_q[k].tnew == '0) ? FW'(k) : '0;
    end
  end

  // E-stage forwarding: same rule, only stages behind E, using latched sources.
  always_comb begin
    fwd_e_rs = '0;
    fwd_e_rt = '0;
    for (int k = STAGES; k >= 2; k--) begin
      if (src_match(st_q[k], esrc_q.rs, esrc_q.rs_use)) fwd_e_rs = (st_q[k].tnew == '0) ? FW'(k) : '0;
      if (src_match(st_q[k], esrc_q.rt, esrc_q.rt_use)) fwd_e_rt = (st_q[k].tnew == '0) ? FW'(k) : '0;
    end
  end

  assign e_md_start = st_q[1].valid & esrc_q.md_start;
  assign hilo_stall = d_hilo & (md_busy_w | e_md_start);
  assign stall      = raw_rs | raw_rt | hilo_stall;
  assign bubble     = stall | flush;
  assign md_busy    = md_busy_w;

  // ---------------------------------------------------------------------------
  // Shadow pipeline next state
  // ---------------------------------------------------------------------------
  always_comb begin
    st_d[1] = '0;
    esrc_d  = '0;
    if (!bubble) begin
      st_d[1].valid   = 1'b1;
      st_d[1].wa      = REG_AW_MAX'(d_wa);
      st_d[1].we      = d_we;
      st_d[1].tnew    = TW_MAX'(d_tnew);
      esrc_d.rs       = rs_x;
      esrc_d.rt       = rt_x;
      esrc_d.rs_use   = d_rs_use;
      esrc_d.rt_use   = d_rt_use;
      esrc_d.md_start = d_md_start;
      esrc_d.md_div   = d_md_div;
    end
    for (int k = 2; k <= STAGES; k++) begin
      st_d[k]      = st_q[k-1];
      st_d[k].tnew = tnew_sat_dec(st_q[k-1].tnew);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= STAGES; k++) st_q[k] <= '0;
      esrc_q <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) st_q[k] <= st_d[k];
      esrc_q <= esrc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO busy countdown
  // ---------------------------------------------------------------------------
  md_busy_cnt #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (e_md_start),
    .div_i  (esrc_q.md_div),
    .busy_o (md_busy_w)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_raw_q, perf_raw_d;
  logic [31:0] perf_hilo_q, perf_hilo_d;

  always_comb begin
    perf_raw_d  = perf_raw_q;
    perf_hilo_d = perf_hilo_q;
    if (raw_rs | raw_rt) perf_raw_d  = perf_raw_q + 32'd1;
    if (hilo_stall)      perf_hilo_d = perf_hilo_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_raw_q  <= '0;
      perf_hilo_q <= '0;
    end else begin
      perf_raw_q  <= perf_raw_d;
      perf_hilo_q <= perf_hilo_d;
    end
  end

  assign perf_stall_raw  = perf_raw_q;
  assign perf_stall_hilo = perf_hilo_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl (default build, STAGES=3, MUL_LAT=5,
// DIV_LAT=10). Inputs change 1 ns after the rising edge; outputs are checked
// 2 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_rs_use, d_rt_use, d_we, d_hilo, d_md_start, d_md_div, flush;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_rs_use   (d_rs_use),
    .d_rt_use   (d_rt_use),
    .d_wa       (d_wa),
    .d_we       (d_we),
    .d_tnew     (d_tnew),
    .d_hilo     (d_hilo),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .flush      (flush),
    .stall      (stall),
    .fwd_d_rs   (fwd_d_rs),
    .fwd_d_rt   (fwd_d_rt),
    .fwd_e_rs   (fwd_e_rs),
    .fwd_e_rt   (fwd_e_rt),
    .md_busy    (md_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    d_rs = '0; d_rt = '0; d_tuse_rs = '0; d_tuse_rt = '0;
    d_rs_use = 1'b0; d_rt_use = 1'b0;
    d_wa = '0; d_we = 1'b0; d_tnew = '0;
    d_hilo = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic writer(input logic [4:0] wa, input logic [1:0] tnew);
    idle();
    d_wa = wa; d_we = 1'b1; d_tnew = tnew;
  endtask

  task automatic reader(input logic [4:0] rs, input logic [1:0] tuse_rs, input logic rs_use,
                        input logic [4:0] rt, input logic [1:0] tuse_rt, input logic rt_use);
    idle();
    d_rs = rs; d_tuse_rs = tuse_rs; d_rs_use = rs_use;
    d_rt = rt; d_tuse_rt = tuse_rt; d_rt_use = rt_use;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) tick();
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_fwd_d_rs", fwd_d_rs, 0);
    chk("rst_fwd_e_rs", fwd_e_rs, 0);
    rst_n = 1'b1;
    tick();

    // lw $8 (tnew 2) then beq $8,$9 (tuse 0)
    writer(5'd8, 2'd2);
    settle();
    chk("lw_nostall", stall, 0);
    tick();
    reader(5'd8, 2'd0, 1'b1, 5'd9, 2'd0, 1'b1);
    settle();
    chk("beq_stall1", stall, 1);
    chk("beq_fwd_pending", fwd_d_rs, 0);
    tick();
    settle();
    chk("beq_stall2", stall, 1);
    tick();
    settle();
    chk("beq_release", stall, 0);
    chk("beq_fwd_rs_w", fwd_d_rs, 3);
    chk("beq_fwd_rt_rf", fwd_d_rt, 0);
    tick();
    drain();

    // addu $8 then addu $10,$8,$8 (tuse 1)
    writer(5'd8, 2'd1);
    tick();
    reader(5'd8, 2'd1, 1'b1, 5'd8, 2'd1, 1'b1);
    d_wa = 5'd10; d_we = 1'b1; d_tnew = 2'd1;
    settle();
    chk("alu_nostall", stall, 0);
    chk("alu_fwd_d_notready", fwd_d_rs, 0);
    tick();
    idle();
    settle();
    chk("alu_fwd_e_rs", fwd_e_rs, 2);
    chk("alu_fwd_e_rt", fwd_e_rt, 2);
    drain();

    // addu $8 then jr $8 (tuse 0)
    writer(5'd8, 2'd1);
    tick();
    reader(5'd8, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0);
    settle();
    chk("jr_stall", stall, 1);
    tick();
    settle();
    chk("jr_release", stall, 0);
    chk("jr_fwd_m", fwd_d_rs, 2);
    tick();
    drain();

    // $0 is never a hazard
    writer(5'd0, 2'd1);
    tick();
    reader(5'd0, 2'd0, 1'b1, 5'd0, 2'd0, 1'b1);
    settle();
    chk("zero_nostall", stall, 0);
    chk("zero_nofwd", fwd_d_rs, 0);
    tick();
    settle();
    chk("zero_nostall2", stall, 0);
    drain();

    // mult then mflo: 6 stall cycles, busy in the last 5
    idle();
    d_hilo = 1'b1; d_md_start = 1'b1;
    settle();
    chk("mult_issue_nostall", stall, 0);
    tick();
    idle();
    d_hilo = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("mult_stall_%0d", i), stall, 1);
      chk($sformatf("mult_busy_%0d", i), md_busy, (i >= 1) ? 1 : 0);
      tick();
    end
    settle();
    chk("mult_release_stall", stall, 0);
    chk("mult_release_busy", md_busy, 0);
    tick();
    drain();

    // div then mflo: 11 stall cycles
    idle();
    d_hilo = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
    settle();
    chk("div_issue_nostall", stall, 0);
    tick();
    idle();
    d_hilo = 1'b1;
    for (int i = 0; i < 11; i++) begin
      settle();
      chk($sformatf("div_stall_%0d", i), stall, 1);
      chk($sformatf("div_busy_%0d", i), md_busy, (i >= 1) ? 1 : 0);
      tick();
    end
    settle();
    chk("div_release_stall", stall, 0);
    chk("div_release_busy", md_busy, 0);
    tick();
    drain();

    // div again, async reset in the middle of busy
    idle();
    d_hilo = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
    tick();
    idle();
    d_hilo = 1'b1;
    repeat (4) tick();
    settle();
    chk("div_pre_reset_busy", md_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("div_reset_busy", md_busy, 0);
    chk("div_reset_stall", stall, 0);
    tick();
    rst_n = 1'b1;
    drain();

    // two writers of $8 (tnew 0): nearest wins
    writer(5'd8, 2'd0);
    tick();
    writer(5'd8, 2'd0);
    tick();
    reader(5'd8, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0);
    settle();
    chk("near_stall", stall, 0);
    chk("near_fwd_e", fwd_d_rs, 1);
    // flushed writer of $9 must leave no trace
    writer(5'd9, 2'd0);
    flush = 1'b1;
    tick();
    reader(5'd9, 2'd0, 1'b1, 5'd8, 2'd0, 1'b1);
    settle();
    chk("flush_no_match", fwd_d_rs, 0);
    chk("flush_rt_m", fwd_d_rt, 2);
    chk("flush_nostall", stall, 0);
    tick();
    drain();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised next-generation stall/forward controller for the in-order MIPS pipeline (F/D/E/M/W and deeper variants).
- Tracks in-flight destinations in an internal shadow pipeline instead of taking Tnew from the datapath.
- Emits the D-stage stall, bubble-insert and forwarding selects for D- and E-stage operands.
- Owns the HI/LO multiply/divide busy countdown.

Parameters:
- REG_AW, 5, register address width; address 0 is hardwired zero and never a hazard.
- STAGES, 3, shadow stages after D (E, M, W, ...), minimum 2.
- TW, 2, width of Tuse/Tnew fields.
- MUL_LAT, 5, busy cycles for mult/multu.
- DIV_LAT, 10, busy cycles for div/divu.
- FW, $clog2(STAGES+1), width of forwarding selects.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- d_rs  in  REG_AW  D-stage rs address.
- d_rt  in  REG_AW  D-stage rt address.
- d_tuse_rs  in  TW  cycles until rs is consumed (0 = in D).
- d_tuse_rt  in  TW  same, for rt.
- d_rs_use  in  1  D instruction reads rs.
- d_rt_use  in  1  D instruction reads rt.
- d_wa  in  REG_AW  D instruction destination.
- d_we  in  1  D instruction writes the register file.
- d_tnew  in  TW  cycles after entering E until the result is forwardable.
- d_hilo  in  1  D instruction touches HI/LO (mf/mt/mult/div).
- d_md_start  in  1  D instruction is mult/div.
- d_md_div  in  1  start is a divide (qualifies d_md_start).
- flush  in  1  kill D→E transfer this cycle (insert bubble).
- stall  out  1  hold PC and F/D, bubble into E.
- fwd_d_rs  out  FW  D rs source: 0 = RF, k = shadow stage k (1 = E).
- fwd_d_rt  out  FW  same, for rt.
- fwd_e_rs  out  FW  E rs source: 0 = pipeline register, k = stage k (k ≥ 2).
- fwd_e_rt  out  FW  same, for rt.
- md_busy  out  1  HI/LO unit busy.

Behaviour:
- Shadow entry per stage: {valid, wa, we, tnew}. E additionally holds rs, rt, rs_use, rt_use.
- Every clock edge:
  - Stage k+1 ← stage k, with tnew saturating-decremented (never below 0).
  - If stall|flush, E ← bubble (valid=0, we=0); otherwise E ← D fields.
  - The last stage drops out.
- A stage matches a source when: valid & we & wa == src & src != 0 & src_use.
- Stall on a source when any matching stage has tnew > that source's tuse.
- HI/LO stall: d_hilo & (md_busy | E holds an md start).
- stall = rs hazard | rt hazard | HI/LO stall. Purely combinational from current state and inputs.
- D forward select: the nearest matching stage (lowest k wins) with tnew == 0; 0 if none or the nearest match has tnew > 0 (stall covers that case).
- E forward select: the same rule over stages 2..STAGES using the latched E rs/rt.
- MD counter:
  - Loads MUL_LAT or DIV_LAT on the edge where an md start enters E.
  - Decrements to 0 thereafter; md_busy = (count != 0).
  - A new start cannot coincide with busy; the HI/LO stall prevents it. If it does occur, the reload wins.
- Simultaneous flush and stall: bubble; F/D hold is governed by stall only.
- Reset (any time, async): all stages invalid, counter 0. Outputs: stall=0, all fwd=0, md_busy=0.
- Widths: tnew compare is unsigned TW-bit. Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1).

Optional Feature:
- HAZARD_PERF_EN defined: adds 32-bit counters perf_stall_raw and perf_stall_hilo, plus output ports of the same names.
  - Each counts cycles where that stall cause is asserted (RAW hazard / HI/LO) and wraps at 2^32.
  - Counters clear on reset.
- Macro undefined: no counters and no extra ports; core behaviour identical.

Decomposition:
- Shared package (hazard_pkg) holds:
  - Typedef shadow_entry_t.
  - TNEW_ALU=1, TNEW_LOAD=2, TNEW_LINK=0.
  - TUSE_BRANCH=0, TUSE_ALU=1, TUSE_STORE_RT=2.
  - Default MUL_LAT/DIV_LAT.
- One natural sub-module, md_busy_cnt: load/decrement counter producing md_busy.

Test Plan:
- lw $8 (tnew 2) then beq $8,$9 (tuse 0) → stall=1 for 2 cycles; third cycle stall=0, fwd_d_rs=3 (W).
- addu $8 (tnew 1) then addu $10,$8,$8 (tuse 1) → no stall; next cycle fwd_e_rs=fwd_e_rt=2 (M).
- addu $8 then jr $8 (tuse 0) → stall=1 one cycle, then fwd_d_rs=2; with d_rs=0 instead → never stall.
- mult issued, mflo follows → md_busy high for exactly MUL_LAT=5 cycles; stall=1 for 6 cycles in total (start-in-E cycle plus 5 busy).
- Same sequence with div → stall for DIV_LAT+1=11 cycles; rst_n pulsed low mid-busy → md_busy=0 and stall=0 immediately.
- Two writers to $8 in E (tnew 0) and M → fwd_d_rs=1 (nearest wins); flush asserted → E bubble, next cycle no match from that instruction.
